// File: rtl/pulse_stretch_pkg.sv
// Shared parameter defaults and legal ranges for the multi-channel pulse stretcher.
package pulse_stretch_pkg;

  // Number of independent channels.
  localparam int NCH_DEF = 4;
  localparam int NCH_MIN = 1;
  localparam int NCH_MAX = 32;

  // Width of the length input and of each channel's remaining-count register.
  localparam int CW_DEF = 8;
  localparam int CW_MIN = 2;
  localparam int CW_MAX = 16;

  // Evaluates to 1 when a parameter pair lies inside the supported ranges.
  function automatic bit params_ok(input int nch, input int cw);
    return (nch >= NCH_MIN) && (nch <= NCH_MAX) && (cw >= CW_MIN) && (cw <= CW_MAX);
  endfunction

endpackage

// File: rtl/pulse_stretch_ch.sv
// One pulse-stretcher channel: a remaining-count register, the stretched pulse,
// and a one-cycle done strobe that fires only on natural expiry.
//
// Handshake: none. trig is a level sample; every cycle it is high counts as one
// trigger. A trigger is accepted when en is high, clr is low, len is non-zero,
// and either the channel is idle or retrig is high.
module pulse_stretch_ch
  import pulse_stretch_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic          retrig,
  input  logic [CW-1:0] len,
  input  logic          trig,
  output logic          pulse,
  output logic          done,
  output logic          pulse_nxt
);

  logic [CW-1:0] rem_q, rem_d;
  logic          pulse_q, pulse_d;
  logic          done_q, done_d;
  logic          accept;

  // Accept decision and next-state for the count, pulse and done strobe.
  // len is only looked at here, so a later change cannot touch a running pulse.
  always_comb begin
    accept  = trig & en & ~clr & (len != '0) & (~pulse_q | retrig);
    rem_d   = rem_q;
    if (clr) begin
      rem_d = '0;
    end else if (accept) begin
      rem_d = len;
    end else if (rem_q != '0) begin
      rem_d = rem_q - CW'(1);
    end
    pulse_d = (rem_d != '0);
    // A reload on the last cycle (retrig) or a clear suppresses the strobe.
    done_d  = ~clr & ~accept & (rem_q == CW'(1));
  end

  // Channel state registers; reset aborts a pulse without any strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q   <= '0;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      rem_q   <= rem_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
    end
  end

  assign pulse     = pulse_q;
  assign done      = done_q;
  assign pulse_nxt = pulse_d;

endmodule

// File: rtl/pulse_stretch_mc.sv
// Multi-channel pulse stretcher: NCH independent channels sharing len, en,
// retrig and clr, plus a registered busy flag that is the OR of all pulses.
module pulse_stretch_mc
  import pulse_stretch_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int CW  = CW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           en,
  input  logic           retrig,
  input  logic [CW-1:0]  len,
  input  logic [NCH-1:0] trig,
  output logic [NCH-1:0] pulse,
  output logic [NCH-1:0] done,
  output logic           busy
);

  logic [NCH-1:0] pulse_nxt;
  logic           busy_q, busy_d;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pulse_stretch_ch #(
      .CW(CW)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .en       (en),
      .retrig   (retrig),
      .len      (len),
      .trig     (trig[i]),
      .pulse    (pulse[i]),
      .done     (done[i]),
      .pulse_nxt(pulse_nxt[i])
    );
  end

  // busy is built from the channels' next pulse values so the registered flag
  // lines up cycle-for-cycle with the registered pulse bits.
  always_comb begin
    busy_d = |pulse_nxt;
  end

  // Registered busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_pulse_stretch_mc.sv
// Bench for pulse_stretch_mc: fixed vector table, hand-written corner sequences,
// then randomized traffic against a pulse-end-time reference model.
module tb_pulse_stretch_mc;

  localparam int NCH = 4;
  localparam int CW  = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           clr;
  logic           en;
  logic           retrig;
  logic [CW-1:0]  len;
  logic [NCH-1:0] trig;
  logic [NCH-1:0] pulse;
  logic [NCH-1:0] done;
  logic           busy;

  int checks = 0;
  int errors = 0;

  // Reference model: for each channel, the last cycle in which the pulse is
  // high, and whether its end is a natural expiry that earns a done strobe.
  int end_t[NCH];
  bit done_ok[NCH];
  int cyc;

  typedef struct {
    logic [NCH-1:0] trig;
    logic           retrig;
    logic [CW-1:0]  len;
    logic [NCH-1:0] exp_pulse;
    logic [NCH-1:0] exp_done;
    logic           exp_busy;
  } vec_t;

  vec_t tbl[22];

  // clock block
  always #5 clk = ~clk;

  pulse_stretch_mc #(
    .NCH(NCH),
    .CW (CW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .en    (en),
    .retrig(retrig),
    .len   (len),
    .trig  (trig),
    .pulse (pulse),
    .done  (done),
    .busy  (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      end_t[i]   = -10;
      done_ok[i] = 1'b0;
    end
  endfunction

  // Applies the inputs sampled at this rising edge to the model.
  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < NCH; i++) begin
        bit active;
        active = (cyc <= end_t[i]);
        if (clr) begin
          if (end_t[i] > cyc) end_t[i] = cyc;
          done_ok[i] = 1'b0;
        end else if (trig[i] && en && (len != 0) && (!active || retrig)) begin
          end_t[i]   = cyc + int'(len);
          done_ok[i] = 1'b1;
        end
      end
    end
    cyc++;
  endtask

  task automatic compare_model();
    logic [NCH-1:0] exp_p;
    logic [NCH-1:0] exp_d;
    for (int i = 0; i < NCH; i++) begin
      exp_p[i] = (cyc <= end_t[i]);
      exp_d[i] = done_ok[i] && (cyc == end_t[i] + 1);
    end
    check("model_pulse", 32'(pulse), 32'(exp_p));
    check("model_done", 32'(done), 32'(exp_d));
    check("model_busy", 32'(busy), 32'(|exp_p));
  endtask

  // One clock: inputs set before the rising edge, outputs checked on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_model();
  endtask

  function automatic vec_t mk(input logic [NCH-1:0] t, input logic r, input logic [CW-1:0] l,
                              input logic [NCH-1:0] p, input logic [NCH-1:0] d, input logic b);
    vec_t v;
    v.trig = t; v.retrig = r; v.len = l; v.exp_pulse = p; v.exp_done = d; v.exp_busy = b;
    return v;
  endfunction

  // Bound on total run time.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;

    // Basic non-retrig pulse, len 4.
    tbl[0]  = mk(4'b0001, 1'b0, 8'd4, 4'b0001, 4'b0000, 1'b1);
    tbl[1]  = mk(4'b0000, 1'b0, 8'd4, 4'b0001, 4'b0000, 1'b1);
    tbl[2]  = mk(4'b0000, 1'b0, 8'd4, 4'b0001, 4'b0000, 1'b1);
    tbl[3]  = mk(4'b0000, 1'b0, 8'd4, 4'b0001, 4'b0000, 1'b1);
    tbl[4]  = mk(4'b0000, 1'b0, 8'd4, 4'b0000, 4'b0001, 1'b0);
    tbl[5]  = mk(4'b0000, 1'b0, 8'd4, 4'b0000, 4'b0000, 1'b0);
    // Retrig: second trigger two cycles later extends to six high cycles.
    tbl[6]  = mk(4'b0001, 1'b1, 8'd4, 4'b0001, 4'b0000, 1'b1);
    tbl[7]  = mk(4'b0000, 1'b1, 8'd4, 4'b0001, 4'b0000, 1'b1);
    tbl[8]  = mk(4'b0001, 1'b1, 8'd4, 4'b0001, 4'b0000, 1'b1);
    tbl[9]  = mk(4'b0000, 1'b1, 8'd4, 4'b0001, 4'b0000, 1'b1);
    tbl[10] = mk(4'b0000, 1'b1, 8'd4, 4'b0001, 4'b0000, 1'b1);
    tbl[11] = mk(4'b0000, 1'b1, 8'd4, 4'b0001, 4'b0000, 1'b1);
    tbl[12] = mk(4'b0000, 1'b1, 8'd4, 4'b0000, 4'b0001, 1'b0);
    tbl[13] = mk(4'b0000, 1'b1, 8'd4, 4'b0000, 4'b0000, 1'b0);
    // Non-retrig: the second trigger is lost.
    tbl[14] = mk(4'b0001, 1'b0, 8'd4, 4'b0001, 4'b0000, 1'b1);
    tbl[15] = mk(4'b0000, 1'b0, 8'd4, 4'b0001, 4'b0000, 1'b1);
    tbl[16] = mk(4'b0001, 1'b0, 8'd4, 4'b0001, 4'b0000, 1'b1);
    tbl[17] = mk(4'b0000, 1'b0, 8'd4, 4'b0001, 4'b0000, 1'b1);
    tbl[18] = mk(4'b0000, 1'b0, 8'd4, 4'b0000, 4'b0001, 1'b0);
    tbl[19] = mk(4'b0000, 1'b0, 8'd4, 4'b0000, 4'b0000, 1'b0);
    tbl[20] = mk(4'b0000, 1'b0, 8'd4, 4'b0000, 4'b0000, 1'b0);
    tbl[21] = mk(4'b0000, 1'b0, 8'd4, 4'b0000, 4'b0000, 1'b0);

    // reset block
    cyc = 0;
    model_reset();
    rst = 1'b1; clr = 1'b0; en = 1'b0; retrig = 1'b0; len = '0; trig = '0;
    repeat (3) tick();
    check("reset_pulse", 32'(pulse), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    en  = 1'b1;
    repeat (2) tick();

    // Table-driven vectors.
    for (int k = 0; k < 22; k++) begin
      trig = tbl[k].trig; retrig = tbl[k].retrig; len = tbl[k].len;
      tick();
      check($sformatf("tbl%0d_pulse", k), 32'(pulse), 32'(tbl[k].exp_pulse));
      check($sformatf("tbl%0d_done", k), 32'(done), 32'(tbl[k].exp_done));
      check($sformatf("tbl%0d_busy", k), 32'(busy), 32'(tbl[k].exp_busy));
    end
    trig = '0;

    // len == 0: trigger ignored, no pulse, no done.
    len = 8'd0; trig = 4'b1111;
    tick();
    check("len0_pulse", 32'(pulse), 32'd0);
    trig = '0;
    tick();
    check("len0_done", 32'(done), 32'd0);

    // len == 255: maximum width, no wrap.
    len = 8'd255; trig = 4'b0001;
    tick();
    trig = '0;
    n = 0;
    for (int k = 0; k < 300 && pulse[0]; k++) begin
      n++;
      tick();
    end
    check("len255_width", 32'(n), 32'd255);
    check("len255_done", 32'(done[0]), 32'd1);
    tick();

    // len changed mid-pulse has no effect on the running pulse.
    len = 8'd5; trig = 4'b0001;
    tick();
    trig = '0; len = 8'd2;
    n = 0;
    for (int k = 0; k < 20 && pulse[0]; k++) begin
      n++;
      tick();
    end
    check("lenchg_width", 32'(n), 32'd5);
    check("lenchg_done", 32'(done[0]), 32'd1);
    tick();

    // clr two cycles into a pulse, with a simultaneous trigger on channel 1.
    len = 8'd4; retrig = 1'b0; trig = 4'b0001;
    tick();
    trig = '0;
    tick();
    clr = 1'b1; trig = 4'b0010;
    tick();
    check("clr_pulse", 32'(pulse), 32'd0);
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_done", 32'(done), 32'd0);
    clr = 1'b0; trig = '0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("clr_no_done", 32'(done), 32'd0);
      check("clr_no_pulse", 32'(pulse), 32'd0);
    end

    // Asynchronous reset in the middle of pulses on every channel.
    len = 8'd20; trig = 4'b1111;
    tick();
    trig = '0;
    tick();
    check("rst_pre_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_pulse", 32'(pulse), 32'd0);
    check("rst_async_done", 32'(done), 32'd0);
    check("rst_async_busy", 32'(busy), 32'd0);
    model_reset();
    tick();
    tick();
    // Trigger present at the first edge after release is accepted.
    rst = 1'b0; len = 8'd3; trig = 4'b0100;
    tick();
    check("rst_release_pulse", 32'(pulse), 32'b0100);
    trig = '0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rst_no_done", 32'(done & 4'b1011), 32'd0);
    end

    // Randomized traffic against the model.
    for (int k = 0; k < 2000; k++) begin
      int r;
      trig   = NCH'($urandom);
      en     = ($urandom_range(0, 3) != 0);
      retrig = 1'($urandom_range(0, 1));
      clr    = ($urandom_range(0, 40) == 0);
      rst    = ($urandom_range(0, 300) == 0);
      r      = $urandom_range(0, 19);
      if (r == 0)      len = 8'd0;
      else if (r == 1) len = 8'd255;
      else             len = 8'($urandom_range(1, 12));
      tick();
    end
    rst = 1'b0; clr = 1'b0; trig = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
